// File: rtl/hazard_resolve_unit.sv
// Hazard resolution for the MW stage: operand forwarding, load-use stall on dmem_rdy,
// branch flush sequencing, a fatal load timeout and a saturating stall counter.
module hazard_resolve_unit #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_WAIT     = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_wrMW,
    input  logic [1:0]       wb_selMW,
    input  logic [6:0]       InstF_MW_opcode,
    input  logic [4:0]       rd_MW,
    input  logic [4:0]       rs1_E,
    input  logic [4:0]       rs2_E,
    input  logic             br_taken,
    input  logic             dmem_rdy,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       hz_state,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LD_WAIT = 2'b01,
        FLUSH   = 2'b10,
        ERR     = 2'b11
    } hzState_e;

    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(FLUSH_CYCLES - 1);

    hzState_e           state_q, state_d;
    logic [WAIT_W-1:0]  waitCnt_q, waitCnt_d;
    logic [FLUSH_W-1:0] flushCnt_q, flushCnt_d;
    logic               timeoutErr_q, timeoutErr_d;
    logic [CNT_W-1:0]   stallCnt_q, stallCnt_d;
    logic               ldMW;

    assign ldMW = reg_wrMW & (wb_selMW == 2'b01) & (InstF_MW_opcode == 7'b0000011);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            waitCnt_q    <= '0;
            flushCnt_q   <= '0;
            timeoutErr_q <= 1'b0;
            stallCnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            waitCnt_q    <= waitCnt_d;
            flushCnt_q   <= flushCnt_d;
            timeoutErr_q <= timeoutErr_d;
            stallCnt_q   <= stallCnt_d;
        end
    end

    // A pending load outranks a branch: EX is frozen, so the branch is seen again from IDLE.
    always_comb begin
        state_d      = state_q;
        waitCnt_d    = waitCnt_q;
        flushCnt_d   = flushCnt_q;
        timeoutErr_d = timeoutErr_q;
        stallCnt_d   = stallCnt_q;
        if (stall && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (ldMW && !dmem_rdy) begin
                    state_d   = LD_WAIT;
                    waitCnt_d = WAIT_W'(1);
                end else if (br_taken) begin
                    state_d    = FLUSH;
                    flushCnt_d = FLUSH_INIT;
                end
            end
            LD_WAIT: begin
                if (dmem_rdy) begin
                    state_d = IDLE;
                end else if (waitCnt_q == WAIT_LIMIT) begin
                    state_d      = ERR;
                    timeoutErr_d = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            FLUSH: begin
                if (flushCnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    flushCnt_d = flushCnt_q - 1'b1;
                end
            end
            default: state_d = ERR;
        endcase
    end

    always_comb begin
        fwd_a = 1'b0;
        fwd_b = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        if (rst) begin
            fwd_a = reg_wrMW && (rd_MW != '0) && (rd_MW == rs1_E) && (state_q != FLUSH);
            fwd_b = reg_wrMW && (rd_MW != '0) && (rd_MW == rs2_E) && (state_q != FLUSH);
            flush = (state_q == FLUSH);
            case (state_q)
                IDLE:    stall = ldMW && !dmem_rdy;
                LD_WAIT: stall = !dmem_rdy;
                ERR:     stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
    end

    assign hz_state    = state_q;
    assign timeout_err = timeoutErr_q;
    assign stall_cnt   = stallCnt_q;

endmodule
